// File: rtl/m_encoder_alu.sv
// Re-encodes an ALU control bundle plus register indices into a canonical RRR
// instruction word through a two-stage valid/ready pipeline with error counting.
package m_encoder_alu_pkg;
  typedef enum logic [3:0] {
    CORE_OP_ADD, CORE_OP_AND, CORE_OP_XOR, CORE_OP_SHL, CORE_OP_SHR,
    CORE_OP_ASL, CORE_OP_ASR, CORE_OP_ROL, CORE_OP_ROR
  } e_core_op;
  typedef enum logic [1:0] {UNARY_ID, UNARY_NEG, UNARY_NOT} e_unary;
  typedef enum logic [1:0] {SHIFT_SHL, SHIFT_SHR, SHIFT_ASR, SHIFT_ROL} e_shift_kind;

  typedef struct packed {
    e_shift_kind shift_kind;
    logic [4:0]  shift_amt;
  } s_shift;

  typedef struct packed {
    e_core_op core_op;
    e_unary   unary_a;
    e_unary   unary_b;
    s_shift   shift;
    e_unary   unary_out;
  } s_control;

  localparam int CONTROL_W = $bits(s_control);

  // Canonical bundles: every encodable entry carries a zero SHL shift field.
  localparam logic [CONTROL_W-1:0] BUNDLE_ADD = {CORE_OP_ADD, UNARY_ID,  UNARY_ID,  SHIFT_SHL, 5'd0, UNARY_ID};
  localparam logic [CONTROL_W-1:0] BUNDLE_SUB = {CORE_OP_ADD, UNARY_ID,  UNARY_NEG, SHIFT_SHL, 5'd0, UNARY_ID};
  localparam logic [CONTROL_W-1:0] BUNDLE_AND = {CORE_OP_AND, UNARY_ID,  UNARY_ID,  SHIFT_SHL, 5'd0, UNARY_ID};
  localparam logic [CONTROL_W-1:0] BUNDLE_OR  = {CORE_OP_AND, UNARY_NOT, UNARY_NOT, SHIFT_SHL, 5'd0, UNARY_NOT};
  localparam logic [CONTROL_W-1:0] BUNDLE_XOR = {CORE_OP_XOR, UNARY_ID,  UNARY_ID,  SHIFT_SHL, 5'd0, UNARY_ID};
  localparam logic [CONTROL_W-1:0] BUNDLE_SHL = {CORE_OP_SHL, UNARY_ID,  UNARY_ID,  SHIFT_SHL, 5'd0, UNARY_ID};
  localparam logic [CONTROL_W-1:0] BUNDLE_SHR = {CORE_OP_SHR, UNARY_ID,  UNARY_ID,  SHIFT_SHL, 5'd0, UNARY_ID};
  localparam logic [CONTROL_W-1:0] BUNDLE_ASL = {CORE_OP_ASL, UNARY_ID,  UNARY_ID,  SHIFT_SHL, 5'd0, UNARY_ID};
  localparam logic [CONTROL_W-1:0] BUNDLE_ASR = {CORE_OP_ASR, UNARY_ID,  UNARY_ID,  SHIFT_SHL, 5'd0, UNARY_ID};
  localparam logic [CONTROL_W-1:0] BUNDLE_ROL = {CORE_OP_ROL, UNARY_ID,  UNARY_ID,  SHIFT_SHL, 5'd0, UNARY_ID};
  localparam logic [CONTROL_W-1:0] BUNDLE_ROR = {CORE_OP_ROR, UNARY_ID,  UNARY_ID,  SHIFT_SHL, 5'd0, UNARY_ID};
endpackage

module m_encoder_alu
  import m_encoder_alu_pkg::*;
#(
  parameter int ERR_CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [CONTROL_W-1:0] in_control,
  input  logic [4:0]           in_rd,
  input  logic [4:0]           in_rs1,
  input  logic [4:0]           in_rs2,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [31:0]          out_instr,
  output logic                 out_error,
  output logic [ERR_CNT_W-1:0] err_count,
  input  logic                 err_clear
);

  localparam logic [ERR_CNT_W-1:0] ERR_MAX = '1;

  // Returns {error, opcode}.
  function automatic logic [4:0] classify(input logic [CONTROL_W-1:0] c);
    case (c)
      BUNDLE_ADD: return {1'b0, 4'd0};
      BUNDLE_SUB: return {1'b0, 4'd1};
      BUNDLE_AND: return {1'b0, 4'd2};
      BUNDLE_OR:  return {1'b0, 4'd3};
      BUNDLE_XOR: return {1'b0, 4'd4};
      BUNDLE_SHL: return {1'b0, 4'd5};
      BUNDLE_SHR: return {1'b0, 4'd6};
      BUNDLE_ASL: return {1'b0, 4'd7};
      BUNDLE_ASR: return {1'b0, 4'd8};
      BUNDLE_ROL: return {1'b0, 4'd9};
      BUNDLE_ROR: return {1'b0, 4'd10};
      default:    return {1'b1, 4'd0};
    endcase
  endfunction

  function automatic logic [31:0] assemble(input logic err, input logic [3:0] op,
                                           input logic [4:0] rd, input logic [4:0] rs1,
                                           input logic [4:0] rs2);
    return err ? 32'h0 : {4'h0, op, rd, rs1, rs2, 9'h0};
  endfunction

  logic                 vld_p1_q, vld_p1_d;
  logic                 err_p1_q, err_p1_d;
  logic [3:0]           op_p1_q, op_p1_d;
  logic [4:0]           rd_p1_q, rd_p1_d, rs1_p1_q, rs1_p1_d, rs2_p1_q, rs2_p1_d;
  logic                 vld_p2_q, vld_p2_d;
  logic                 err_p2_q, err_p2_d;
  logic [31:0]          instr_p2_q, instr_p2_d;
  logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;
  logic                 s1_adv, s2_adv, accept;
  logic [4:0]           cls;

  always_comb begin
    s2_adv     = !vld_p2_q || out_ready;
    s1_adv     = !vld_p1_q || s2_adv;
    accept     = in_valid && s1_adv;
    cls        = classify(in_control);

    // Stage 1 boundary: classification and register indices
    vld_p1_d   = s1_adv ? accept : vld_p1_q;
    err_p1_d   = err_p1_q;
    op_p1_d    = op_p1_q;
    rd_p1_d    = rd_p1_q;
    rs1_p1_d   = rs1_p1_q;
    rs2_p1_d   = rs2_p1_q;
    if (accept) begin
      err_p1_d = cls[4];
      op_p1_d  = cls[3:0];
      rd_p1_d  = in_rd;
      rs1_p1_d = in_rs1;
      rs2_p1_d = in_rs2;
    end

    // Stage 2 boundary: assembled word; data holds when a bubble passes
    vld_p2_d   = s2_adv ? vld_p1_q : vld_p2_q;
    err_p2_d   = err_p2_q;
    instr_p2_d = instr_p2_q;
    if (s2_adv && vld_p1_q) begin
      err_p2_d   = err_p1_q;
      instr_p2_d = assemble(err_p1_q, op_p1_q, rd_p1_q, rs1_p1_q, rs2_p1_q);
    end

    err_cnt_d  = err_cnt_q;
    if (err_clear)
      err_cnt_d = '0;
    else if (vld_p2_q && out_ready && err_p2_q && err_cnt_q != ERR_MAX)
      err_cnt_d = err_cnt_q + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p1_q   <= 1'b0;
      err_p1_q   <= 1'b0;
      op_p1_q    <= '0;
      rd_p1_q    <= '0;
      rs1_p1_q   <= '0;
      rs2_p1_q   <= '0;
      vld_p2_q   <= 1'b0;
      err_p2_q   <= 1'b0;
      instr_p2_q <= '0;
      err_cnt_q  <= '0;
    end else begin
      vld_p1_q   <= vld_p1_d;
      err_p1_q   <= err_p1_d;
      op_p1_q    <= op_p1_d;
      rd_p1_q    <= rd_p1_d;
      rs1_p1_q   <= rs1_p1_d;
      rs2_p1_q   <= rs2_p1_d;
      vld_p2_q   <= vld_p2_d;
      err_p2_q   <= err_p2_d;
      instr_p2_q <= instr_p2_d;
      err_cnt_q  <= err_cnt_d;
    end
  end

  assign in_ready  = s1_adv;
  assign out_valid = vld_p2_q;
  assign out_instr = instr_p2_q;
  assign out_error = err_p2_q;
  assign err_count = err_cnt_q;

endmodule

// File: tb/tb_m_encoder_alu.sv
// Bench for m_encoder_alu: directed scenarios plus random traffic, checked
// against a transaction-level scoreboard of expected words and error counts.
module tb_m_encoder_alu;
  import m_encoder_alu_pkg::*;

  localparam int EW = 2;

  logic                 clk = 1'b0;
  logic                 rst, in_valid, in_ready, out_valid, out_ready, out_error, err_clear;
  logic [CONTROL_W-1:0] in_control;
  logic [4:0]           in_rd, in_rs1, in_rs2;
  logic [31:0]          out_instr;
  logic [EW-1:0]        err_count;

  always #5 clk = ~clk;

  m_encoder_alu #(.ERR_CNT_W(EW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_control(in_control), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
    .out_error(out_error), .err_count(err_count), .err_clear(err_clear)
  );

  typedef struct { logic [31:0] word; logic err; int acc; } exp_t;
  exp_t                 q[$];
  int                   checks = 0, failures = 0, cyc = 0, err_model = 0;
  logic                 accepted;
  logic [CONTROL_W-1:0] legal[11];
  logic [CONTROL_W-1:0] bad_shift, bad_unary;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Opcode is the bundle's position in the canonical table; fields packed by arithmetic.
  function automatic void ref_encode(input logic [CONTROL_W-1:0] c, input logic [4:0] rd,
                                     input logic [4:0] rs1, input logic [4:0] rs2,
                                     output logic [31:0] w, output logic e);
    e = 1'b1;
    w = 32'h0;
    for (int i = 0; i < 11; i++)
      if (c == legal[i]) begin
        e = 1'b0;
        w = 32'(i * (2 ** 24) + int'(rd) * (2 ** 19) + int'(rs1) * (2 ** 14) + int'(rs2) * (2 ** 9));
      end
  endfunction

  function automatic logic [4:0] rand5();
    logic [31:0] t;
    t = $urandom;
    return t[4:0];
  endfunction

  task automatic drive(input logic v, input logic [CONTROL_W-1:0] c, input logic [4:0] rd,
                       input logic [4:0] rs1, input logic [4:0] rs2, input logic ordy,
                       input logic clr);
    in_valid = v; in_control = c; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2;
    out_ready = ordy; err_clear = clr;
  endtask

  // One clock: inputs are already driven just after the previous rising edge.
  task automatic cycle();
    logic [31:0] w;
    logic        e;
    @(negedge clk);
    check("in_ready", 32'(in_ready), 32'(out_ready || q.size() < 2));
    check("out_valid", 32'(out_valid), 32'(q.size() > 0 && (cyc - q[0].acc) >= 2));
    if (out_valid && out_ready && q.size() > 0) begin
      check("out_instr", out_instr, q[0].word);
      check("out_error", 32'(out_error), 32'(q[0].err));
      if (q[0].err && err_model < (2 ** EW) - 1) err_model++;
      void'(q.pop_front());
    end
    accepted = in_valid && in_ready;
    if (accepted) begin
      ref_encode(in_control, in_rd, in_rs1, in_rs2, w, e);
      q.push_back('{word: w, err: e, acc: cyc});
    end
    if (err_clear) err_model = 0;
    @(posedge clk);
    cyc++;
    #1;
    check("err_count", 32'(err_count), 32'(err_model));
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      drive(1'b0, '0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0);
      cycle();
    end
  endtask

  initial begin
    legal = '{BUNDLE_ADD, BUNDLE_SUB, BUNDLE_AND, BUNDLE_OR, BUNDLE_XOR, BUNDLE_SHL,
              BUNDLE_SHR, BUNDLE_ASL, BUNDLE_ASR, BUNDLE_ROL, BUNDLE_ROR};
    bad_shift = {CORE_OP_ADD, UNARY_ID, UNARY_ID, SHIFT_SHL, 5'd3, UNARY_ID};
    bad_unary = {CORE_OP_AND, UNARY_NOT, UNARY_ID, SHIFT_SHL, 5'd0, UNARY_ID};
    rst = 1'b1;
    accepted = 1'b0;
    drive(1'b0, '0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", 32'(out_valid), 32'h0);
    check("rst_out_instr", out_instr, 32'h0);
    check("rst_out_error", 32'(out_error), 32'h0);
    check("rst_err_count", 32'(err_count), 32'h0);
    rst = 1'b0;

    // Single sub, two-cycle latency
    drive(1'b1, BUNDLE_SUB, 5'd0, 5'd1, 5'd2, 1'b1, 1'b0);
    cycle();
    idle(1);
    check("sub_valid", 32'(out_valid), 32'h1);
    check("sub_word", out_instr, 32'h0100_4400);
    idle(2);

    // Back-to-back sweep of all opcodes, then add r3,r4,r5
    for (int i = 0; i < 11; i++) begin
      drive(1'b1, legal[i], 5'd0, 5'd1, 5'd2, 1'b1, 1'b0);
      cycle();
    end
    drive(1'b1, BUNDLE_ADD, 5'd3, 5'd4, 5'd5, 1'b1, 1'b0);
    cycle();
    idle(1);
    check("add_r3_word", out_instr, 32'h0019_0A00);
    idle(2);

    // Unencodable bundles and error counting
    drive(1'b1, bad_shift, 5'd7, 5'd8, 5'd9, 1'b1, 1'b0);
    cycle();
    drive(1'b1, bad_unary, 5'd7, 5'd8, 5'd9, 1'b1, 1'b0);
    cycle();
    idle(1);
    check("err_cnt_one", 32'(err_count), 32'h1);
    drive(1'b1, bad_shift, 5'd1, 5'd1, 5'd1, 1'b1, 1'b0);
    cycle();
    check("err_cnt_two", 32'(err_count), 32'h2);
    idle(1);
    drive(1'b0, '0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b1);
    cycle();
    check("err_clear_prio", 32'(err_count), 32'h0);
    idle(2);

    // Backpressure: hold each word until accepted
    begin
      int k = 0;
      for (int t = 0; t < 9; t++) begin
        drive(k < 3, legal[k % 11], 5'(k), 5'(k + 10), 5'(k + 20), t >= 5, 1'b0);
        cycle();
        if (accepted) k++;
      end
      check("bp_all_accepted", 32'(k), 32'd3);
    end
    idle(2);
    check("bp_drained", 32'(q.size()), 32'h0);

    // Saturation of the 2-bit counter
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, bad_unary, rand5(), rand5(), rand5(), 1'b1, 1'b0);
      cycle();
    end
    idle(3);
    check("err_sat", 32'(err_count), 32'h3);

    // Reset with both stages full
    drive(1'b1, BUNDLE_XOR, 5'd1, 5'd2, 5'd3, 1'b0, 1'b0);
    cycle();
    drive(1'b1, bad_shift, 5'd4, 5'd5, 5'd6, 1'b0, 1'b0);
    cycle();
    #2 rst = 1'b1;
    #1;
    check("midrst_out_valid", 32'(out_valid), 32'h0);
    check("midrst_err_count", 32'(err_count), 32'h0);
    check("midrst_out_instr", out_instr, 32'h0);
    q.delete();
    err_model = 0;
    @(posedge clk);
    cyc++;
    #1 rst = 1'b0;
    drive(1'b1, BUNDLE_ROR, 5'd0, 5'd1, 5'd2, 1'b1, 1'b0);
    cycle();
    idle(1);
    check("post_rst_valid", 32'(out_valid), 32'h1);
    check("post_rst_word", out_instr, 32'h0A00_4400);
    idle(2);

    // Random traffic
    for (int t = 0; t < 400; t++) begin
      logic [31:0]          r;
      logic [CONTROL_W-1:0] c;
      r = $urandom;
      c = r[0] ? legal[$urandom_range(0, 10)] : r[CONTROL_W + 1:2];
      drive($urandom_range(0, 3) != 0, c, rand5(), rand5(), rand5(),
            $urandom_range(0, 3) != 0, $urandom_range(0, 19) == 0);
      cycle();
    end
    idle(3);
    check("final_drained", 32'(q.size()), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
